tlk2711_tx_pattern_gen: RTL

- Test-pattern source that writes 64-bit frames into the TLK2711 TX FIFO.
- It is the producer side of the TX FIFO self-check. The FIFO-side checker verifies the data it generates.
- It sits in front of the TX FIFO write port and is muxed with the DMA write path when test mode is selected.
- Frame length follows i_tx_mode. Frame count, inter-frame gap and backpressure are handled here.

---
 rtl/tlk2711_tx_pattern_gen_if.sv | 12 +
 rtl/tlk2711_tx_pattern_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tlk2711_tx_pattern_gen_if.sv
// Write-side bus from the pattern generator into the TLK2711 TX FIFO.
// A word moves on every clock edge where o_valid and i_ready are both high; while
// o_valid is high and i_ready is low, o_data/o_last stay constant and o_valid holds.
interface tlk2711_tx_pattern_gen_if;
  logic        o_valid;
  logic [63:0] o_data;
  logic        o_last;
  logic        i_ready;

  modport master (output o_valid, output o_data, output o_last, input i_ready);
  modport slave  (input o_valid, input o_data, input o_last, output i_ready);
endinterface

// File: rtl/tlk2711_tx_pattern_gen.sv
// Test-pattern producer for the TLK2711 TX FIFO self-check: framed ramp words,
// a tail word per frame, a frame count per run and a fixed inter-frame gap.
module tlk2711_tx_pattern_gen #(
  parameter int          LEN_MODE3   = 5376,
  parameter int          LEN_DEFAULT = 434,
  parameter int          GAP_CYCLES  = 16,
  parameter logic [63:0] TAIL_WORD   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_soft_rst,
  input  logic                             i_gen_ena,
  input  logic                             i_tx_start,
  input  logic [2:0]                       i_tx_mode,
  input  logic [15:0]                      i_frame_num,
  tlk2711_tx_pattern_gen_if.master         tx,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [15:0]                      o_frame_cnt,
  output logic [2:0]                       o_state
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE} state_t;

  localparam logic [15:0] LEN3     = 16'(LEN_MODE3);
  localparam logic [15:0] LEN_DEF  = 16'(LEN_DEFAULT);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state, state_next;
  logic        start_q, start_r, start_p;
  logic [15:0] len, len_next;
  logic [15:0] num, num_next;
  logic [15:0] gen, gen_next;
  logic [15:0] word_cnt, word_next;
  logic [15:0] frame_cnt, frame_next;
  logic [15:0] gap_cnt, gap_next;
  logic        send, tail, xfer;

  // start_q samples the pin; the edge is taken between start_q and start_r,
  // so a start first seen at edge N reaches LOAD at N+1.
  assign start_p = start_q & ~start_r;
  assign send    = (state == S_SEND);
  assign tail    = (word_cnt == len);
  assign xfer    = send & tx.i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          state <= S_IDLE;
    else if (i_soft_rst) state <= S_IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    len_next   = len;
    num_next   = num;
    gen_next   = gen;
    word_next  = word_cnt;
    frame_next = frame_cnt;
    gap_next   = gap_cnt;
    if (!i_gen_ena) begin
      if (state != S_IDLE) begin
        state_next = S_IDLE;
        gen_next   = 16'h0001;
        word_next  = 16'd0;
      end
    end else begin
      case (state)
        S_IDLE: if (start_p) state_next = S_LOAD;
        S_LOAD: begin
          len_next   = (i_tx_mode == 3'd3) ? LEN3 : LEN_DEF;
          num_next   = i_frame_num;
          gen_next   = 16'h0001;
          word_next  = 16'd0;
          frame_next = 16'd0;
          state_next = S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            if (!tail) begin
              word_next = word_cnt + 16'd1;
              gen_next  = gen + 16'h0202;
            end else begin
              frame_next = frame_cnt + 16'd1;
              gen_next   = 16'h0001;
              word_next  = 16'd0;
              gap_next   = 16'd0;
              if ((num != 16'd0) && (frame_cnt + 16'd1 == num)) state_next = S_DONE;
              else if (GAP_CYCLES == 0)                         state_next = S_SEND;
              else                                              state_next = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state_next = S_SEND;
          else                     gap_next   = gap_cnt + 16'd1;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      start_r   <= 1'b0;
      len       <= LEN_DEF;
      num       <= 16'd0;
      gen       <= 16'h0001;
      word_cnt  <= 16'd0;
      frame_cnt <= 16'd0;
      gap_cnt   <= 16'd0;
    end else if (i_soft_rst) begin
      start_q   <= 1'b0;
      start_r   <= 1'b0;
      len       <= LEN_DEF;
      num       <= 16'd0;
      gen       <= 16'h0001;
      word_cnt  <= 16'd0;
      frame_cnt <= 16'd0;
      gap_cnt   <= 16'd0;
    end else begin
      start_q   <= i_tx_start;
      start_r   <= start_q;
      len       <= len_next;
      num       <= num_next;
      gen       <= gen_next;
      word_cnt  <= word_next;
      frame_cnt <= frame_next;
      gap_cnt   <= gap_next;
    end
  end

  // Data is forced to zero outside SEND so an abort or reset clears the bus at once.
  assign tx.o_valid  = send;
  assign tx.o_last   = send & tail;
  assign tx.o_data   = !send ? 64'd0 : (tail ? TAIL_WORD : {4{gen}});
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_frame_cnt = frame_cnt;
  assign o_state     = state;

endmodule
